// File: rtl/ln_stat_ctrl.sv
// LayerNorm statistics sequencer: accumulates sum / sum-of-squares over one
// N-sample vector, hands E[x] and E[x^2] to preprocess, and holds the result for downstream.
module ln_stat_ctrl #(
    parameter int unsigned DATA_W = 8,
    parameter int unsigned LOG2_N = 6
) (
    input  logic                     i_clk,
    input  logic                     i_rstn,
    input  logic                     i_start,
    output logic                     o_busy,
    input  logic                     i_x_valid,
    input  logic signed [DATA_W-1:0] i_x,
    output logic                     o_x_ready,
    output logic                     o_pre_valid,
    output logic [21:0]              o_Ex,
    output logic [31:0]              o_Ex2,
    input  logic                     i_pre_done,
    input  logic [21:0]              i_mean,
    input  logic [7:0]               i_std,
    output logic                     o_stat_valid,
    input  logic                     i_stat_ready,
    output logic [21:0]              o_mean,
    output logic [7:0]               o_std,
    output logic                     o_err
);

    localparam int unsigned N     = 1 << LOG2_N;
    localparam int unsigned SUM_W = DATA_W + LOG2_N;
    localparam int unsigned SQ_W  = 2 * DATA_W + LOG2_N;
    localparam int unsigned CNT_W = LOG2_N + 1;
    localparam int unsigned MUL_W = 2 * DATA_W;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ACCUM = 2'd1,
        PRE   = 2'd2,
        OUT   = 2'd3
    } state_e;

    state_e                   state_q, state_d;
    logic signed [SUM_W-1:0]  sum_q, sum_d;
    logic [SQ_W-1:0]          sumsq_q, sumsq_d;
    logic [CNT_W-1:0]         count_q, count_d;
    logic [21:0]              mean_q, mean_d;
    logic [7:0]               std_q, std_d;
    logic                     err_q, err_d;

    logic signed [MUL_W-1:0]  x_sq;
    logic signed [SUM_W-1:0]  ex_s;

    // State and datapath registers
    always_ff @(posedge i_clk) begin
        if (!i_rstn) begin
            state_q <= IDLE;
            sum_q   <= '0;
            sumsq_q <= '0;
            count_q <= '0;
            mean_q  <= '0;
            std_q   <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sum_q   <= sum_d;
            sumsq_q <= sumsq_d;
            count_q <= count_d;
            mean_q  <= mean_d;
            std_q   <= std_d;
            err_q   <= err_d;
        end
    end

    // Next-state and register update
    always_comb begin
        state_d = state_q;
        sum_d   = sum_q;
        sumsq_d = sumsq_q;
        count_d = count_q;
        mean_d  = mean_q;
        std_d   = std_q;
        err_d   = err_q;
        x_sq    = i_x * i_x;

        case (state_q)
            IDLE: begin
                if (i_start) begin
                    sum_d   = '0;
                    sumsq_d = '0;
                    count_d = '0;
                    state_d = ACCUM;
                end
            end
            ACCUM: begin
                if (i_x_valid) begin
                    sum_d   = sum_q + SUM_W'(i_x);
                    sumsq_d = sumsq_q + SQ_W'($unsigned(x_sq));
                    count_d = count_q + CNT_W'(1);
                    if (count_q == CNT_W'(N - 1)) begin
                        state_d = PRE;
                    end
                end
            end
            // Preprocess is combinational, so its answer is valid on this same edge
            PRE: begin
                mean_d  = i_mean;
                std_d   = i_std;
                err_d   = ~i_pre_done;
                state_d = OUT;
            end
            OUT: begin
                if (i_stat_ready) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Outputs decoded from registered state and accumulators
    always_comb begin
        ex_s         = sum_q >>> LOG2_N;
        o_Ex         = 22'(ex_s);
        o_Ex2        = 32'(sumsq_q >> LOG2_N);
        o_busy       = (state_q != IDLE);
        o_x_ready    = (state_q == ACCUM);
        o_pre_valid  = (state_q == PRE);
        o_stat_valid = (state_q == OUT);
        o_mean       = mean_q;
        o_std        = std_q;
        o_err        = err_q;
    end

endmodule

// File: tb/tb_ln_stat_ctrl.sv
// Directed bench for ln_stat_ctrl with N=4, DATA_W=8 and a stand-in preprocess model.
module tb_ln_stat_ctrl;

    logic               clk = 1'b0;
    logic               rstn;
    logic               start;
    logic               busy;
    logic               x_valid;
    logic signed [7:0]  x;
    logic               x_ready;
    logic               pre_valid;
    logic [21:0]        ex;
    logic [31:0]        ex2;
    logic               pre_done;
    logic [21:0]        pre_mean;
    logic [7:0]         pre_std;
    logic               stat_valid;
    logic               stat_ready;
    logic [21:0]        mean;
    logic [7:0]         std_code;
    logic               err;

    int n_cmp = 0;
    int n_err = 0;

    ln_stat_ctrl #(.DATA_W(8), .LOG2_N(2)) dut (
        .i_clk        (clk),
        .i_rstn       (rstn),
        .i_start      (start),
        .o_busy       (busy),
        .i_x_valid    (x_valid),
        .i_x          (x),
        .o_x_ready    (x_ready),
        .o_pre_valid  (pre_valid),
        .o_Ex         (ex),
        .o_Ex2        (ex2),
        .i_pre_done   (pre_done),
        .i_mean       (pre_mean),
        .i_std        (pre_std),
        .o_stat_valid (stat_valid),
        .i_stat_ready (stat_ready),
        .o_mean       (mean),
        .o_std        (std_code),
        .o_err        (err)
    );

    always #5 clk = ~clk;

    // Stand-in preprocess: var = Ex2 - Ex^2, std code = 256/sqrt(2^floor(log2 var))
    function automatic logic [7:0] std_of(input longint v);
        int p;
        int s;
        p = 0;
        for (int i = 0; i < 40; i++) begin
            if (v >= (64'sd1 <<< i)) p = i;
        end
        s = (p % 2 == 0) ? (256 >> (p / 2)) : (181 >> (p / 2));
        if (s > 255) s = 255;
        return 8'(s);
    endfunction

    always_comb begin
        longint ex_v;
        longint var_v;
        ex_v     = longint'($signed(ex));
        var_v    = longint'(ex2) - ex_v * ex_v;
        pre_mean = ex;
        pre_std  = 8'd0;
        pre_done = 1'b0;
        if (var_v > 0) begin
            pre_std  = std_of(var_v);
            pre_done = 1'b1;
        end
    end

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic run_vec(input int xs[4], input int gap, input int hold, input bit glitch,
                           input int e_ex, input int e_ex2, input int e_std, input bit e_err);
        logic [21:0] e22;
        e22 = 22'(e_ex);
        start = 1'b1;
        tick();
        start = 1'b0;
        chk("accum_ready", 32'(x_ready), 32'd1);
        chk("accum_busy", 32'(busy), 32'd1);
        for (int k = 0; k < 4; k++) begin
            x_valid = 1'b1;
            x       = 8'(xs[k]);
            if (glitch && k == 1) start = 1'b1;
            tick();
            start   = 1'b0;
            x_valid = 1'b0;
            if (k < 3) begin
                for (int g = 0; g < gap; g++) begin
                    chk("stall_no_pre", 32'(pre_valid), 32'd0);
                    chk("stall_ready", 32'(x_ready), 32'd1);
                    tick();
                end
            end
        end
        chk("pre_valid", 32'(pre_valid), 32'd1);
        chk("pre_ex", 32'(ex), 32'(e22));
        chk("pre_ex2", ex2, 32'(e_ex2));
        chk("pre_no_stat", 32'(stat_valid), 32'd0);
        tick();
        chk("out_valid", 32'(stat_valid), 32'd1);
        chk("out_pre_low", 32'(pre_valid), 32'd0);
        chk("out_mean", 32'(mean), 32'(e22));
        chk("out_std", 32'(std_code), 32'(e_std));
        chk("out_err", 32'(err), 32'(e_err));
        stat_ready = 1'b0;
        for (int h = 0; h < hold; h++) begin
            if (glitch) start = 1'b1;
            tick();
            start = 1'b0;
            chk("hold_valid", 32'(stat_valid), 32'd1);
            chk("hold_mean", 32'(mean), 32'(e22));
            chk("hold_std", 32'(std_code), 32'(e_std));
        end
        stat_ready = 1'b1;
        start      = glitch;
        tick();
        stat_ready = 1'b0;
        start      = 1'b0;
        chk("idle_valid", 32'(stat_valid), 32'd0);
        chk("idle_busy", 32'(busy), 32'd0);
        tick();
        chk("idle_stays", 32'(busy), 32'd0);
        chk("idle_ready", 32'(x_ready), 32'd0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        int v1[4] = '{1, 2, 3, 4};
        int v2[4] = '{-3, -1, 1, 3};
        int v3[4] = '{5, 5, 5, 5};
        int v4[4] = '{-4, -4, -4, -4};
        int v6[4] = '{-128, -128, -128, -128};

        rstn = 1'b0; start = 1'b0; x_valid = 1'b0; x = '0; stat_ready = 1'b0;
        tick(); tick();
        rstn = 1'b1;
        tick();
        chk("rst_busy", 32'(busy), 32'd0);
        chk("rst_ready", 32'(x_ready), 32'd0);
        chk("rst_stat", 32'(stat_valid), 32'd0);
        chk("rst_mean", 32'(mean), 32'd0);
        chk("rst_std", 32'(std_code), 32'd0);
        chk("rst_err", 32'(err), 32'd0);

        // Basic vector, back-to-back samples
        run_vec(v1, 0, 0, 1'b0, 2, 7, 181, 1'b0);
        // Stalled samples
        run_vec(v2, 2, 0, 1'b0, 0, 5, 128, 1'b0);
        // Zero variance, positive and negative
        run_vec(v3, 0, 0, 1'b0, 5, 25, 0, 1'b1);
        run_vec(v4, 0, 0, 1'b0, -4, 16, 0, 1'b1);
        // Backpressure with ignored starts in ACCUM and OUT
        run_vec(v1, 0, 3, 1'b1, 2, 7, 181, 1'b0);

        // Mid-vector reset
        start = 1'b1; tick(); start = 1'b0;
        x_valid = 1'b1; x = 8'sd1; tick();
        x = 8'sd2; tick();
        x_valid = 1'b0;
        rstn = 1'b0; tick(); rstn = 1'b1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_ready", 32'(x_ready), 32'd0);
        chk("mid_rst_stat", 32'(stat_valid), 32'd0);
        chk("mid_rst_mean", 32'(mean), 32'd0);
        chk("mid_rst_std", 32'(std_code), 32'd0);
        chk("mid_rst_ex", 32'(ex), 32'd0);
        chk("mid_rst_ex2", ex2, 32'd0);
        tick();
        chk("mid_rst_idle", 32'(busy), 32'd0);
        run_vec(v1, 0, 0, 1'b0, 2, 7, 181, 1'b0);

        // Full-scale negative samples
        run_vec(v6, 0, 0, 1'b0, -128, 16384, 0, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
